// File: rtl/controller_button_pio.sv
// Avalon-MM input PIO: two-flop synchronizer, per-bit debounce, edge capture
// with write-1-to-clear, and a level interrupt masked by IRQMASK.
module controller_button_pio #(
    parameter int WIDTH     = 8,
    parameter int DEBOUNCE  = 16,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int             CW        = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [1:0]     ADDR_DATA = 2'd0;
    localparam logic [1:0]     ADDR_MASK = 2'd2;
    localparam logic [1:0]     ADDR_EDGE = 2'd3;
    localparam logic           CAP_RISE  = (EDGE_TYPE != 1);
    localparam logic           CAP_FALL  = (EDGE_TYPE != 0);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] event_s, clear_s;
    logic [31:0]      rd_mux_s;
    logic             write_s;
    logic             unused_wdata_s;

    assign write_s        = chipselect & ~write_n;
    assign unused_wdata_s = ^writedata;

    // Per-bit debounce: count consecutive mismatch cycles, accept on the last one.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = {CW{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Edge capture, mask update and registered read mux.
    always_comb begin
        event_s = ((stable_d & ~stable_q) & {WIDTH{CAP_RISE}}) |
                  ((~stable_d & stable_q) & {WIDTH{CAP_FALL}});
        if (write_s && (address == ADDR_EDGE)) begin
            clear_s = writedata[WIDTH-1:0];
        end else begin
            clear_s = {WIDTH{1'b0}};
        end
        // The set term is OR-ed last so a simultaneous event beats the clear.
        edgecap_d = (edgecap_q & ~clear_s) | event_s;
        if (write_s && (address == ADDR_MASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end else begin
            irqmask_d = irqmask_q;
        end
        case (address)
            ADDR_DATA: rd_mux_s = 32'(stable_q);
            ADDR_MASK: rd_mux_s = 32'(irqmask_q);
            ADDR_EDGE: rd_mux_s = 32'(edgecap_q);
            default:   rd_mux_s = 32'd0;
        endcase
        if (chipselect) begin
            readdata_d = rd_mux_s;
        end else begin
            readdata_d = readdata_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= {WIDTH{1'b0}};
            sync2_q    <= {WIDTH{1'b0}};
            stable_q   <= {WIDTH{1'b0}};
            edgecap_q  <= {WIDTH{1'b0}};
            irqmask_q  <= {WIDTH{1'b0}};
            readdata_q <= 32'd0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_controller_button_pio.sv
// Bench for controller_button_pio: rising-capture and falling-capture units
// share stimulus and are compared every cycle against a window-based model.
module tb_controller_button_pio;

    localparam int W = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset, chipselect, write_n;
    logic [1:0]    address;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0, rd1;
    logic          irq0, irq1;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    controller_button_pio #(.WIDTH(W), .DEBOUNCE(D), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0));

    controller_button_pio #(.WIDTH(W), .DEBOUNCE(D), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in_port), .irq(irq1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a bit's accepted value flips once the input as seen through the
    // two-flop delay has been the opposite value for the last D sampled edges.
    logic [W-1:0] h [0:D];
    logic [W-1:0] m_stable, m_cap0, m_cap1, m_mask;
    logic [31:0]  m_rd0, m_rd1;
    bit           started = 1'b0;

    function automatic logic [31:0] regmux(input logic [1:0] a, input logic [W-1:0] st,
                                           input logic [W-1:0] mk, input logic [W-1:0] cp);
        case (a)
            2'd0:    return 32'(st);
            2'd2:    return 32'(mk);
            2'd3:    return 32'(cp);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] upd, nst, clr;
        started <= 1'b1;
        if (reset) begin
            for (int i = 0; i <= D; i++) h[i] <= '0;
            m_stable <= '0; m_cap0 <= '0; m_cap1 <= '0; m_mask <= '0;
            m_rd0 <= 32'd0; m_rd1 <= 32'd0;
        end else begin
            for (int b = 0; b < W; b++) begin
                upd[b] = 1'b1;
                for (int i = 1; i <= D; i++)
                    if (h[i][b] == m_stable[b]) upd[b] = 1'b0;
            end
            nst = m_stable ^ upd;
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            m_cap0 <= (m_cap0 & ~clr) | (upd & nst);
            m_cap1 <= (m_cap1 & ~clr) | (upd & ~nst);
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[W-1:0];
            if (chipselect) begin
                m_rd0 <= regmux(address, m_stable, m_mask, m_cap0);
                m_rd1 <= regmux(address, m_stable, m_mask, m_cap1);
            end
            m_stable <= nst;
            for (int i = D; i > 0; i--) h[i] <= h[i-1];
            h[0] <= in_port;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_readdata0", rd0, m_rd0);
            chk("cyc_readdata1", rd1, m_rd1);
            chk("cyc_irq0", {31'd0, irq0}, {31'd0, |(m_cap0 & m_mask)});
            chk("cyc_irq1", {31'd0, irq1}, {31'd0, |(m_cap1 & m_mask)});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e1,
                      input string name);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        tick(1);
        chipselect = 1'b0;
        chk({name, "_u0"}, rd0, e0);
        chk({name, "_u1"}, rd1, e1);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
        writedata = 32'd0; in_port = '0;
        tick(2);
        chk("rst_irq0", {31'd0, irq0}, 32'd0);
        chk("rst_irq1", {31'd0, irq1}, 32'd0);
        reset = 1'b0;
        rd(2'd0, 32'd0, 32'd0, "rst_data");
        rd(2'd1, 32'd0, 32'd0, "rst_resv");
        rd(2'd2, 32'd0, 32'd0, "rst_mask");
        rd(2'd3, 32'd0, 32'd0, "rst_cap");
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd0, 32'd0, 32'd0, "ro_data");
        rd(2'd1, 32'd0, 32'd0, "ro_resv");

        // Rising accept with continuous DATA reads to pin the latency.
        chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
        in_port = 8'h01;
        tick(6);
        chk("rise_early", rd0, 32'd0);
        tick(1);
        chk("rise_data", rd0, 32'h01);
        chipselect = 1'b0;
        rd(2'd3, 32'h01, 32'h00, "rise_cap");
        chk("rise_irq_unmasked", {31'd0, irq0}, 32'd0);
        wr(2'd2, 32'h01);
        chk("mask_irq0", {31'd0, irq0}, 32'd1);
        chk("mask_irq1", {31'd0, irq1}, 32'd0);
        rd(2'd2, 32'h01, 32'h01, "mask_rd");

        // Three-cycle glitch on bit1 is rejected.
        chipselect = 1'b1; address = 2'd0;
        in_port = 8'h03;
        tick(3);
        in_port = 8'h01;
        tick(8);
        chk("glitch_data", rd0, 32'h01);
        chipselect = 1'b0;
        rd(2'd3, 32'h01, 32'h00, "glitch_cap");

        // Write-1-to-clear.
        wr(2'd3, 32'h01);
        chk("clr_irq0", {31'd0, irq0}, 32'd0);
        rd(2'd3, 32'h00, 32'h00, "clr_cap");

        // Falling edge: only the falling-capture unit records it.
        in_port = 8'h00;
        tick(8);
        rd(2'd3, 32'h00, 32'h01, "fall_cap");
        chk("fall_irq1", {31'd0, irq1}, 32'd1);
        chk("fall_irq0", {31'd0, irq0}, 32'd0);
        rd(2'd0, 32'h00, 32'h00, "fall_data");
        wr(2'd3, 32'h01);
        chk("fall_clr_irq1", {31'd0, irq1}, 32'd0);

        // Clear lands on the same edge as a new rising event: set wins.
        in_port = 8'h01;
        tick(5);
        wr(2'd3, 32'h01);
        chk("coll_irq0", {31'd0, irq0}, 32'd1);
        rd(2'd3, 32'h01, 32'h00, "coll_cap");

        // Reset while bit2 is mid-debounce (count 2).
        in_port = 8'h04;
        tick(4);
        reset = 1'b1;
        tick(2);
        chk("rstmid_irq0", {31'd0, irq0}, 32'd0);
        reset = 1'b0;
        chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
        tick(1);
        chk("rstmid_data", rd0, 32'd0);
        address = 2'd3;
        tick(5);
        chk("rstmid_early", rd0, 32'd0);
        tick(1);
        chk("rstmid_cap0", rd0, 32'h04);
        chk("rstmid_cap1", rd1, 32'h00);
        chipselect = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller_button_pio.md
# controller_button_pio

Avalon-MM slave input port with synchronization, per-bit debounce, edge capture and interrupt generation. It is the read-direction counterpart to the controller's output PIO registers: it brings external pins (buttons, status lines) into the Nios II register space. It sits on the controller's Avalon-MM interconnect, and its `irq` is routed to the processor's interrupt controller.

## Interface
- `WIDTH`, default 8: number of input bits, legal range 1..32.
- `DEBOUNCE`, default 16: consecutive cycles a synchronized bit must differ from its accepted value before the change is accepted; must be ≥1.
- `EDGE_TYPE`, default 0: 0 = capture rising edges, 1 = capture falling edges, 2 = capture both.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `address` input 2: register word select.
- `chipselect` input 1: slave access strobe.
- `write_n` input 1: active-low write qualifier.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data, read latency 1.
- `in_port` input WIDTH: asynchronous external inputs.
- `irq` output 1: level interrupt, active-high.

## Operation
- **Register map:**
  - 0 = DATA (RO, debounced value).
  - 1 = reserved (reads 0, writes ignored).
  - 2 = IRQMASK (RW, WIDTH bits).
  - 3 = EDGECAPTURE (read; write-1-to-clear).
- Unused upper bits of `readdata` read 0. Writes to address 0 are ignored.
- **Synchronizer:** two flops per bit (`sync1`, `sync2`). Both reset to 0.
- **Debounce:** runs per bit, with a counter of width clog2(DEBOUNCE+1) and a `stable` flop.
  - If `sync2` equals `stable`, the counter is cleared to 0.
  - Otherwise, if the counter equals DEBOUNCE-1: `stable` ← `sync2` and the counter ← 0.
  - Otherwise the counter increments.
  - A mismatch that lasts fewer than DEBOUNCE consecutive cycles never reaches `stable`.
- **Edge event:** generated on the same edge that `stable` updates.
  - Rising event: 0→1 update.
  - Falling event: 1→0 update.
  - Which events are captured is selected by `EDGE_TYPE`.
- **EDGECAPTURE:** a bit is set on its edge event. A write to address 3 clears every bit whose `writedata` bit is 1. If an edge event and a clear hit the same bit in the same cycle, the set wins.
- **IRQMASK:** loaded with `writedata[WIDTH-1:0]` on a write to address 2.
- A write is `chipselect` && !`write_n`.
- `irq` = |(EDGECAPTURE & IRQMASK), formed combinationally from registers, so it has no added latency.
- **Reset values:** `sync1`, `sync2`, `stable`, counters, IRQMASK, EDGECAPTURE and `readdata` are all 0; `irq` is 0.
- **Reset mid-debounce:** counters are cleared and any pending change is discarded. An input held at 1 through reset is re-accepted after sync plus DEBOUNCE cycles and produces a rising event.

## Timing
- Let `in_port` bit change before edge N.
  - `sync1` at N, `sync2` at N+1.
  - Mismatch is counted at edges N+2 … N+1+DEBOUNCE.
  - `stable` and the EDGECAPTURE bit update at edge N+1+DEBOUNCE.
  - `irq` is high (if masked in) in the cycle after that edge.
- **Read:** `readdata` is loaded at the edge where `chipselect` is high, with the mux value for `address`. It holds that value until the next chipselect cycle and is valid in the following cycle (latency 1, no wait states).
- **Write:** takes effect at the edge where `chipselect` && !`write_n`. A read in the next cycle returns the new value.
- **Write then IRQ:** a write of IRQMASK or an EDGECAPTURE clear changes `irq` in the cycle after the write edge.

## Test plan
All scenarios use WIDTH=8, DEBOUNCE=4 unless stated.
- **Reset:** assert `reset` 2 cycles, then read addresses 0–3 → all return 0x00000000; `irq`=0 throughout.
- **Rising edge accept:** drive `in_port`=0x01 before edge N and hold it.
  - DATA reads 0x01 from edge N+5.
  - EDGECAPTURE reads 0x01.
  - `irq` stays 0 while IRQMASK=0.
  - After writing 0x01 to address 2, `irq`=1 the next cycle.
- **Glitch reject:** pulse bit1 high for 3 cycles, then low → DATA stays 0x00, EDGECAPTURE stays 0x00, `irq` stays 0.
- **Clear and collision:**
  - With EDGECAPTURE=0x01, write 0x01 to address 3 → reads 0x00 and `irq` drops next cycle.
  - Repeat with the clear write on the same edge as a new event on bit0 → bit0 remains 1.
- **EDGE_TYPE=1:** a 0→1 accepted change sets no capture bit. A subsequent 1→0 accepted change sets the bit and asserts `irq` with the mask set.
- **Reset mid-debounce:** hold bit2=1 and assert `reset` at count 2 → DATA=0 after reset. The change is re-accepted 6 edges after reset deasserts, EDGECAPTURE=0x04.
